// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer
//   Feeds operand pairs from a small FIFO into an 8x8 repeated-add multiplier.
//   It holds mul_start for at least SETTLE cycles and waits for mul_done.
//   When done arrives, it captures mul_sum and presents it on a valid/ready port.
//   If done never arrives, it aborts after TIMEOUT cycles and flags out_err.
//
// Ports
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        operand handshake (in_ready = FIFO not full)
//   in_a, in_b               operands
//   mul_a, mul_b, mul_start  registered multiplier drive
//   mul_done, mul_sum        multiplier status / product
//   out_valid/out_ready      result handshake
//   out_prod, out_err        captured product (0 on abort), abort flag
//   busy                     anything in flight, queued or held
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | mul_start low; launch head of FIFO once output slot frees
// ST_WAIT | mul_start high, operands stable; wait for done or timeout
module mul_operand_sequencer #(
    parameter int DEPTH   = 4,
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    output logic        mul_start,
    input  logic        mul_done,
    input  logic [15:0] mul_sum,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_prod,
    output logic        out_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [7:0]    SETTLE_C  = 8'(SETTLE);
    localparam logic [7:0]    TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [15:0]   mem [DEPTH];
    logic [7:0]    cnt;
    logic          push, launch, cap_ok, cap_err, out_free;

    assign in_ready = (count != DEPTH_C);
    assign push     = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;
    assign busy     = (state != ST_IDLE) | (count != '0) | out_valid;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        cap_ok    = 1'b0;
        cap_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0 && out_free) begin
                    launch    = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // done wins over a timeout landing in the same cycle
                if (cnt >= SETTLE_C && mul_done) begin
                    cap_ok    = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt == TIMEOUT_C) begin
                    cap_err   = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Storage needs no reset; validity is tracked by pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_a, in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (launch) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, launch})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            cnt       <= '0;
        end else if (launch) begin
            {mul_a, mul_b} <= mem[rd_ptr];
            mul_start      <= 1'b1;
            cnt            <= '0;
        end else if (state == ST_WAIT) begin
            cnt <= (cnt == TIMEOUT_C) ? cnt : cnt + 8'd1;
            if (cap_ok || cap_err) begin
                mul_start <= 1'b0;
            end
        end
    end

    // A capture may coincide with the consumer taking the old result;
    // the new one simply replaces it and out_valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_prod  <= '0;
            out_err   <= 1'b0;
        end else if (cap_ok) begin
            out_valid <= 1'b1;
            out_prod  <= mul_sum;
            out_err   <= 1'b0;
        end else if (cap_err) begin
            out_valid <= 1'b1;
            out_prod  <= '0;
            out_err   <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_operand_sequencer.sv
module tb_mul_operand_sequencer;

    localparam int DEPTH   = 4;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a, in_b;
    logic [7:0]  mul_a, mul_b;
    logic        mul_start;
    logic        mul_done;
    logic [15:0] mul_sum;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_prod;
    logic        out_err;
    logic        busy;
    logic        done_en;

    int n_checks = 0;
    int n_pass   = 0;
    int n_acc    = 0;

    typedef struct {
        logic [15:0] prod;
        logic        err;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Multiplier stand-in: answers whenever started, unless done is disabled.
    assign mul_done = done_en & mul_start;
    assign mul_sum  = 16'(mul_a) * 16'(mul_b);

    mul_operand_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
        .mul_done(mul_done), .mul_sum(mul_sum),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_prod(out_prod), .out_err(out_err), .busy(busy)
    );

    // Scoreboard: record accepted pairs, compare each consumed result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && in_valid && in_ready) begin
            e.prod = done_en ? 16'(in_a) * 16'(in_b) : 16'd0;
            e.err  = ~done_en;
            sb.push_back(e);
            n_acc++;
        end
        if (rst_n && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL result_unexpected: got prod=%0d err=%0b, expected no result", out_prod, out_err);
            end else begin
                e = sb.pop_front();
                if (out_prod !== e.prod || out_err !== e.err)
                    $display("FAIL result: got prod=%0d err=%0b, expected prod=%0d err=%0b",
                             out_prod, out_err, e.prod, e.err);
                else
                    n_pass++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int max_cyc);
        int c = 0;
        while (sb.size() != 0 && c < max_cyc) begin
            tick();
            c++;
        end
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        out_ready = 1'b1; done_en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_checks += 7;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b expected 1", in_ready); else n_pass++;
        if (busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", busy); else n_pass++;
        if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b expected 0", out_valid); else n_pass++;
        if (mul_start !== 1'b0) $display("FAIL rst_mul_start: got %0b expected 0", mul_start); else n_pass++;
        if (out_prod !== 16'd0) $display("FAIL rst_out_prod: got %0d expected 0", out_prod); else n_pass++;
        if (out_err !== 1'b0) $display("FAIL rst_out_err: got %0b expected 0", out_err); else n_pass++;
        if ({mul_a, mul_b} !== 16'd0) $display("FAIL rst_mul_ab: got %0h expected 0", {mul_a, mul_b}); else n_pass++;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        in_a = 8'd13; in_b = 8'd11; in_valid = 1'b1;
        tick();                      // E0: push
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();                  // E1..E3
            n_checks += 2;
            if (mul_start !== 1'b1) $display("FAIL single_start_hi: edge %0d got %0b expected 1", k, mul_start); else n_pass++;
            if (out_valid !== 1'b0) $display("FAIL single_early_valid: edge %0d got %0b expected 0", k, out_valid); else n_pass++;
        end
        tick();                      // E4: capture
        n_checks += 4;
        if (mul_start !== 1'b0) $display("FAIL single_start_lo: got %0b expected 0", mul_start); else n_pass++;
        if (out_valid !== 1'b1) $display("FAIL single_valid: got %0b expected 1", out_valid); else n_pass++;
        if (out_prod !== 16'd143) $display("FAIL single_prod: got %0d expected 143", out_prod); else n_pass++;
        if (out_err !== 1'b0) $display("FAIL single_err: got %0b expected 0", out_err); else n_pass++;
        wait_drain(20);
    endtask

    task automatic test_corners();
        logic [7:0] ca [4] = '{8'd0, 8'd255, 8'd255, 8'd1};
        logic [7:0] cb [4] = '{8'd200, 8'd0, 8'd255, 8'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a = ca[i]; in_b = cb[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        wait_drain(60);
    endtask

    task automatic test_backpressure();
        logic [7:0] pa [6] = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd10, 8'd12};
        logic [7:0] pb [6] = '{8'd3, 8'd5, 8'd7, 8'd9, 8'd11, 8'd13};
        int idx = 0;
        int acc0 = n_acc;
        logic [15:0] held;
        out_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (idx < 6) begin
                in_a = pa[idx]; in_b = pb[idx]; in_valid = 1'b1;
            end
            if (in_ready && idx < 6) idx++;
            tick();
        end
        n_checks += 5;
        if (n_acc - acc0 != 5) $display("FAIL bp_accepted: got %0d expected 5", n_acc - acc0); else n_pass++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0b expected 0", in_ready); else n_pass++;
        if (mul_start !== 1'b0) $display("FAIL bp_mul_start: got %0b expected 0", mul_start); else n_pass++;
        if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %0b expected 1", out_valid); else n_pass++;
        if (out_prod !== 16'd6) $display("FAIL bp_out_prod: got %0d expected 6", out_prod); else n_pass++;
        held = out_prod;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks += 2;
            if (mul_start !== 1'b0) $display("FAIL bp_hold_start: got %0b expected 0", mul_start); else n_pass++;
            if (out_prod !== held) $display("FAIL bp_hold_prod: got %0d expected %0d", out_prod, held); else n_pass++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_drain(100);
    endtask

    task automatic test_timeout();
        out_ready = 1'b1;
        done_en = 1'b0;
        in_a = 8'd3; in_b = 8'd4; in_valid = 1'b1;
        tick();                      // push
        in_valid = 1'b0;
        tick();                      // launch
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL to_early: %0d after launch got %0b expected 0", k, out_valid); else n_pass++;
        end
        tick();                      // TIMEOUT+1 after launch
        n_checks += 3;
        if (out_valid !== 1'b1) $display("FAIL to_valid: got %0b expected 1", out_valid); else n_pass++;
        if (out_err !== 1'b1) $display("FAIL to_err: got %0b expected 1", out_err); else n_pass++;
        if (out_prod !== 16'd0) $display("FAIL to_prod: got %0d expected 0", out_prod); else n_pass++;
        done_en = 1'b1;
        tick();
        in_a = 8'd5; in_b = 8'd6; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_drain(30);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_a = 8'(i + 20); in_b = 8'd3; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        sb.delete();
        n_checks += 6;
        if (mul_start !== 1'b0) $display("FAIL rm_mul_start: got %0b expected 0", mul_start); else n_pass++;
        if ({mul_a, mul_b} !== 16'd0) $display("FAIL rm_mul_ab: got %0h expected 0", {mul_a, mul_b}); else n_pass++;
        if (out_valid !== 1'b0) $display("FAIL rm_out_valid: got %0b expected 0", out_valid); else n_pass++;
        if (out_prod !== 16'd0) $display("FAIL rm_out_prod: got %0d expected 0", out_prod); else n_pass++;
        if (busy !== 1'b0) $display("FAIL rm_busy: got %0b expected 0", busy); else n_pass++;
        if (in_ready !== 1'b1) $display("FAIL rm_in_ready: got %0b expected 1", in_ready); else n_pass++;
        tick();
        rst_n = 1'b1;
        tick();
        in_a = 8'd7; in_b = 8'd9; in_valid = 1'b1;
        tick();                      // E0
        in_valid = 1'b0;
        tick(); tick(); tick();      // E1..E3
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL rm_early: got %0b expected 0", out_valid); else n_pass++;
        tick();                      // E4
        n_checks += 2;
        if (out_valid !== 1'b1) $display("FAIL rm_valid: got %0b expected 1", out_valid); else n_pass++;
        if (out_prod !== 16'd63) $display("FAIL rm_prod: got %0d expected 63", out_prod); else n_pass++;
        wait_drain(20);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pa [4] = '{8'd17, 8'd200, 8'd99, 8'd128};
        logic [7:0] pb [4] = '{8'd19, 8'd3, 8'd101, 8'd2};
        int idx = 0;
        int launches = 0;
        int c = 0;
        logic prev_start;
        logic [15:0] prev_ab;
        out_ready = 1'b0;
        prev_start = mul_start;
        prev_ab = {mul_a, mul_b};
        while ((idx < 4 || sb.size() != 0) && c < 100) begin
            if (idx < 4) begin
                in_a = pa[idx]; in_b = pb[idx]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) idx++;
            tick();
            out_ready = ~out_ready;
            c++;
            if (mul_start && !prev_start) launches++;
            if (prev_start && mul_start) begin
                n_checks++;
                if ({mul_a, mul_b} !== prev_ab)
                    $display("FAIL b2b_no_gap: operands %0h -> %0h with start held", prev_ab, {mul_a, mul_b});
                else
                    n_pass++;
            end
            prev_start = mul_start;
            prev_ab = {mul_a, mul_b};
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        n_checks += 2;
        if (launches != 4) $display("FAIL b2b_launches: got %0d expected 4", launches); else n_pass++;
        if (sb.size() != 0) begin
            $display("FAIL b2b_drain: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_corners();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
